// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register, BOOT/RUN/FAULT control.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/stall_cnt performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] fpc_plus4_s;
    logic        misaligned_s;
    logic        bubble_s;
    logic        capture_s;
    logic        stall_evt_s;

    assign fpc_plus4_s  = fpc_q + 32'd4;
    assign misaligned_s = (pc_target_e[1:0] != 2'b00);

    // Control FSM: next state, next PC and IF/ID load selection.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        fault_d     = fault_q;
        bubble_s    = 1'b0;
        capture_s   = 1'b0;
        stall_evt_s = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d  = ST_RUN;
                bubble_s = 1'b1;
            end
            ST_RUN: begin
                stall_evt_s = stall_f & ~pc_src_e;
                if (pc_src_e && misaligned_s) begin
                    // A misaligned target is never fetched; the PC stays put for debug.
                    state_d  = ST_FAULT;
                    fault_d  = 1'b1;
                    bubble_s = 1'b1;
                end else begin
                    if (pc_src_e) begin
                        fpc_d = pc_target_e;
                    end else if (stall_f) begin
                        fpc_d = fpc_q;
                    end else begin
                        fpc_d = fpc_plus4_s;
                    end
                    if (flush_d) begin
                        bubble_s = 1'b1;
                    end else if (stall_d) begin
                        bubble_s = 1'b0;
                    end else begin
                        capture_s = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                fault_d  = 1'b1;
                bubble_s = 1'b1;
            end
            default: begin
                state_d  = ST_FAULT;
                fault_d  = 1'b1;
                bubble_s = 1'b1;
            end
        endcase
    end

    // IF/ID next value: capture, bubble (PC fields kept), or hold.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (capture_s) begin
            ifid_instr_d = imem_rdata;
            ifid_pc_d    = fpc_q;
            ifid_pc4_d   = fpc_plus4_s;
            ifid_valid_d = 1'b1;
        end else if (bubble_s) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_valid_d = ifid_valid_q;
        end
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BOOT;
            fpc_q        <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'h0000_0000;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fault_q      <= fault_d;
        end
    end

    assign imem_addr  = fpc_q;
    assign instr_d    = ifid_instr_q;
    assign pc_d       = ifid_pc_q;
    assign pc_plus4_d = ifid_pc4_q;
    assign valid_d    = ifid_valid_q;
    assign fault      = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture_s) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (stall_evt_s) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
